// File: rtl/pe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pe_pkg : shared defaults, width helpers and state type for psum_acc  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pe_pkg;

  localparam int c_BIT_WIDTH  = 8;
  localparam int c_ACC_WIDTH  = 16;
  localparam int c_ACC_LEN    = 9;
  localparam int c_FIFO_DEPTH = 4;

  // Floors at 1 so a single-beat group still gets a legal counter width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/psum_acc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psum_acc_if : PE partial-sum stream in, result handshake out         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface psum_acc_if #(
  parameter int BIT_WIDTH = pe_pkg::c_BIT_WIDTH,
  parameter int ACC_WIDTH = pe_pkg::c_ACC_WIDTH
);
  logic [BIT_WIDTH-1:0] i_psum;
  logic                 i_psum_val;
  logic                 i_clr;
  logic [ACC_WIDTH-1:0] o_result;
  logic                 o_result_val;
  logic                 i_result_rdy;
  logic                 o_busy;
  logic                 o_ovf;
  logic                 o_drop;

  modport master (
    output i_psum, i_psum_val, i_clr, i_result_rdy,
    input  o_result, o_result_val, o_busy, o_ovf, o_drop
  );

  modport slave (
    input  i_psum, i_psum_val, i_clr, i_result_rdy,
    output o_result, o_result_val, o_busy, o_ovf, o_drop
  );
endinterface
`default_nettype wire

// File: rtl/psum_acc_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psum_fifo : synchronous FIFO with flush, wrap-bit full/empty         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module psum_fifo
  import pe_pkg::*;
#(
  parameter int WIDTH = c_ACC_WIDTH,
  parameter int DEPTH = c_FIFO_DEPTH
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_clr,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire logic [WIDTH-1:0] i_wdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [WIDTH-1:0]      o_head
);
  localparam int c_AW = clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  // A pop frees the slot being written, so a full FIFO still accepts a push.
  assign w_rd_en = i_pop && !o_empty;
  assign w_wr_en = i_push && (!o_full || w_rd_en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en && !i_clr) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
  end

  // Storage is not reset, so the head is forced to zero while empty.
  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/psum_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | psum_acc : accumulates ACC_LEN psum beats per result, queues results |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module psum_acc
  import pe_pkg::*;
#(
  parameter int BIT_WIDTH  = c_BIT_WIDTH,
  parameter int ACC_WIDTH  = c_ACC_WIDTH,
  parameter int ACC_LEN    = c_ACC_LEN,
  parameter int FIFO_DEPTH = c_FIFO_DEPTH
) (
  input  wire logic  clk,
  input  wire logic  rst,
  psum_acc_if.slave  bus
);
  localparam int                 c_CNT_W = clog2(ACC_LEN);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(ACC_LEN - 1);

  acc_state_t           r_state;
  acc_state_t           w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_acc_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic                 r_ovf;
  logic                 w_ovf_nxt;
  logic                 r_drop;
  logic                 w_drop_nxt;

  logic                 w_beat;
  logic                 w_last;
  logic                 w_push;
  logic                 w_pop;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_full;
  logic                 w_empty;
  logic [ACC_WIDTH-1:0] w_head;

  assign w_beat = bus.i_psum_val && !bus.i_clr;
  assign w_last = (r_cnt == c_LAST);
  assign w_push = w_beat && w_last;
  assign w_pop  = bus.i_result_rdy && !w_empty;

  // One spare MSB captures the carry out of the accumulator.
  assign w_sum = {1'b0, r_acc} + {{(ACC_WIDTH - BIT_WIDTH + 1){1'b0}}, bus.i_psum};

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_drop_nxt  = r_drop;
    if (bus.i_clr) begin
      w_state_nxt = ST_IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_drop_nxt  = 1'b0;
    end else if (w_beat) begin
      w_ovf_nxt = r_ovf | w_sum[ACC_WIDTH];
      if (w_last) begin
        w_state_nxt = ST_IDLE;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_drop_nxt  = r_drop | (w_full && !w_pop);
      end else begin
        w_state_nxt = ST_ACCUM;
        w_acc_nxt   = w_sum[ACC_WIDTH-1:0];
        w_cnt_nxt   = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  psum_fifo #(
    .WIDTH (ACC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (bus.i_clr),
    .i_push  (w_push),
    .i_pop   (bus.i_result_rdy),
    .i_wdata (w_sum[ACC_WIDTH-1:0]),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign bus.o_result     = w_head;
  assign bus.o_result_val = !w_empty;
  assign bus.o_busy       = (r_state == ST_ACCUM);
  assign bus.o_ovf        = r_ovf;
  assign bus.o_drop       = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_psum_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_psum_acc : directed self-checking bench for psum_acc              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_psum_acc;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  psum_acc_if #(.BIT_WIDTH(8), .ACC_WIDTH(16)) bus  ();
  psum_acc_if #(.BIT_WIDTH(8), .ACC_WIDTH(8))  bus8 ();

  psum_acc #(.BIT_WIDTH(8), .ACC_WIDTH(16), .ACC_LEN(9), .FIFO_DEPTH(4))
    u_dut  (.clk(clk), .rst(rst), .bus(bus));
  psum_acc #(.BIT_WIDTH(8), .ACC_WIDTH(8), .ACC_LEN(9), .FIFO_DEPTH(4))
    u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] v);
    bus.i_psum     = v;
    bus.i_psum_val = 1'b1;
    step();
    bus.i_psum_val = 1'b0;
  endtask

  task automatic beat8(input logic [7:0] v);
    bus8.i_psum     = v;
    bus8.i_psum_val = 1'b1;
    step();
    bus8.i_psum_val = 1'b0;
  endtask

  task automatic clear();
    bus.i_clr = 1'b1;
    step();
    bus.i_clr = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.o_result, bus.o_result_val, bus.o_busy, bus.o_ovf, bus.o_drop} !== 20'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 00000", {bus.o_result, bus.o_result_val, bus.o_busy, bus.o_ovf, bus.o_drop});
    end
    n_cmp++;
    if ({bus8.o_result, bus8.o_result_val, bus8.o_busy, bus8.o_ovf, bus8.o_drop} !== 12'h0) begin
      n_err++;
      $display("FAIL reset_outputs8: got %h want 000", {bus8.o_result, bus8.o_result_val, bus8.o_busy, bus8.o_ovf, bus8.o_drop});
    end
  endtask

  task automatic test_sum();
    bus.i_result_rdy = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      beat(8'(i));
      if (i == 1) begin
        n_cmp++;
        if (bus.o_busy !== 1'b1) begin
          n_err++;
          $display("FAIL sum_busy_beat1: got %b want 1", bus.o_busy);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (bus.o_result_val !== 1'b0) begin
          n_err++;
          $display("FAIL sum_early_val: got %b want 0", bus.o_result_val);
        end
      end
    end
    n_cmp++;
    if (bus.o_result_val !== 1'b1 || bus.o_result !== 16'd45) begin
      n_err++;
      $display("FAIL sum_result: got val=%b res=%0d want val=1 res=45", bus.o_result_val, bus.o_result);
    end
    n_cmp++;
    if (bus.o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL sum_busy_after: got %b want 0", bus.o_busy);
    end
    step();
    n_cmp++;
    if (bus.o_result_val !== 1'b0) begin
      n_err++;
      $display("FAIL sum_val_one_cycle: got %b want 0", bus.o_result_val);
    end
  endtask

  task automatic test_ovf();
    bus8.i_result_rdy = 1'b1;
    for (int i = 0; i < 9; i++) beat8(8'd255);
    n_cmp++;
    if (bus8.o_result_val !== 1'b1 || bus8.o_result !== 8'd247) begin
      n_err++;
      $display("FAIL ovf_result: got val=%b res=%0d want val=1 res=247", bus8.o_result_val, bus8.o_result);
    end
    n_cmp++;
    if (bus8.o_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_flag: got %b want 1", bus8.o_ovf);
    end
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (bus8.o_ovf !== 1'b1 || bus8.o_result_val !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_sticky: got ovf=%b val=%b want ovf=1 val=0", bus8.o_ovf, bus8.o_result_val);
    end
    bus8.i_clr = 1'b1;
    step();
    bus8.i_clr = 1'b0;
    n_cmp++;
    if (bus8.o_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear: got %b want 0", bus8.o_ovf);
    end
  endtask

  task automatic test_drop();
    int got;
    clear();
    bus.i_result_rdy = 1'b0;
    for (int i = 0; i < 45; i++) beat(8'd1);
    n_cmp++;
    if (bus.o_drop !== 1'b1 || bus.o_result_val !== 1'b1 || bus.o_result !== 16'd9) begin
      n_err++;
      $display("FAIL drop_flag: got drop=%b val=%b res=%0d want drop=1 val=1 res=9", bus.o_drop, bus.o_result_val, bus.o_result);
    end
    bus.i_result_rdy = 1'b1;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.o_result_val) begin
        got++;
        n_cmp++;
        if (bus.o_result !== 16'd9) begin
          n_err++;
          $display("FAIL drop_drain_value: got %0d want 9", bus.o_result);
        end
      end
      step();
    end
    n_cmp++;
    if (got !== 4 || bus.o_result_val !== 1'b0) begin
      n_err++;
      $display("FAIL drop_drain_count: got %0d val=%b want 4 val=0", got, bus.o_result_val);
    end
    clear();
    n_cmp++;
    if (bus.o_drop !== 1'b0) begin
      n_err++;
      $display("FAIL drop_clear: got %b want 0", bus.o_drop);
    end
  endtask

  task automatic test_full_pop();
    logic [15:0] exp [4];
    int got;
    exp[0] = 16'd9; exp[1] = 16'd9; exp[2] = 16'd9; exp[3] = 16'd18;
    clear();
    bus.i_result_rdy = 1'b0;
    for (int i = 0; i < 36; i++) beat(8'd1);
    for (int i = 0; i < 8; i++) beat(8'd2);
    bus.i_result_rdy = 1'b1;
    beat(8'd2);
    n_cmp++;
    if (bus.o_drop !== 1'b0 || bus.o_result_val !== 1'b1) begin
      n_err++;
      $display("FAIL fullpop_nodrop: got drop=%b val=%b want drop=0 val=1", bus.o_drop, bus.o_result_val);
    end
    got = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.o_result_val) begin
        n_cmp++;
        if (got < 4 && bus.o_result !== exp[got]) begin
          n_err++;
          $display("FAIL fullpop_value%0d: got %0d want %0d", got, bus.o_result, exp[got]);
        end
        got++;
      end
      step();
    end
    n_cmp++;
    if (got !== 4) begin
      n_err++;
      $display("FAIL fullpop_count: got %0d want 4", got);
    end
  endtask

  task automatic test_clr();
    clear();
    bus.i_result_rdy = 1'b1;
    for (int i = 0; i < 4; i++) beat(8'd10);
    n_cmp++;
    if (bus.o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL clr_busy_before: got %b want 1", bus.o_busy);
    end
    bus.i_clr = 1'b1;
    beat(8'd10);
    bus.i_clr = 1'b0;
    n_cmp++;
    if (bus.o_busy !== 1'b0 || bus.o_result_val !== 1'b0) begin
      n_err++;
      $display("FAIL clr_busy_after: got busy=%b val=%b want 0 0", bus.o_busy, bus.o_result_val);
    end
    for (int i = 0; i < 8; i++) beat(8'd2);
    n_cmp++;
    if (bus.o_result_val !== 1'b0) begin
      n_err++;
      $display("FAIL clr_early_val: got %b want 0", bus.o_result_val);
    end
    beat(8'd2);
    n_cmp++;
    if (bus.o_result_val !== 1'b1 || bus.o_result !== 16'd18) begin
      n_err++;
      $display("FAIL clr_result: got val=%b res=%0d want val=1 res=18", bus.o_result_val, bus.o_result);
    end
    step();
  endtask

  task automatic test_async_rst();
    clear();
    bus.i_result_rdy = 1'b0;
    for (int i = 0; i < 18; i++) beat(8'd1);
    for (int i = 0; i < 4; i++) beat(8'd5);
    n_cmp++;
    if (bus.o_result_val !== 1'b1 || bus.o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL arst_setup: got val=%b busy=%b want 1 1", bus.o_result_val, bus.o_busy);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.o_result, bus.o_result_val, bus.o_busy, bus.o_ovf, bus.o_drop} !== 20'h0) begin
      n_err++;
      $display("FAIL arst_outputs: got %h want 00000", {bus.o_result, bus.o_result_val, bus.o_busy, bus.o_ovf, bus.o_drop});
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    bus.i_result_rdy = 1'b1;
    for (int i = 0; i < 9; i++) beat(8'd3);
    n_cmp++;
    if (bus.o_result_val !== 1'b1 || bus.o_result !== 16'd27) begin
      n_err++;
      $display("FAIL arst_result: got val=%b res=%0d want val=1 res=27", bus.o_result_val, bus.o_result);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.i_psum = '0;  bus.i_psum_val = 1'b0;  bus.i_clr = 1'b0;  bus.i_result_rdy = 1'b0;
    bus8.i_psum = '0; bus8.i_psum_val = 1'b0; bus8.i_clr = 1'b0; bus8.i_result_rdy = 1'b0;
    step();
    step();
    test_reset();
    rst = 1'b1;
    step();
    test_sum();
    test_ovf();
    test_drop();
    test_full_pop();
    test_clr();
    test_async_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
